// File: rtl/macc_dot_engine_if.sv
`timescale 1ns/1ps
// macc_dot_engine_if: job control, A/B read port and C write port signals
// for the dot-product engine. The engine uses the slave view; the host/BRAM
// side uses the master view.
interface macc_dot_engine_if;
  logic        start;
  logic        hold;
  logic        a_re;
  logic        b_re;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic        c_we;
  logic [31:0] c_data;
  logic        busy;
  logic        done;
  logic        ovf;

  modport slave (
    input  start, hold, a_data, b_data,
    output a_re, b_re, c_we, c_data, busy, done, ovf
  );

  modport master (
    output start, hold, a_data, b_data,
    input  a_re, b_re, c_we, c_data, busy, done, ovf
  );
endinterface

// File: rtl/macc_dot_engine.sv
`timescale 1ns/1ps
// macc_dot_engine: issues paired A/B reads, multiply-accumulates DOT_LEN
// products per output word and writes NUM_OUT scaled words to C per start.
// Build macro MACC_ENGINE_SAT_EN: when defined the shifted accumulator is
// clamped to the signed 32-bit range and clamps set the sticky ovf flag;
// when undefined the low 32 bits are written and ovf stays low.
//
// state   | meaning
// S_IDLE  | waiting for start
// S_RUN   | issuing A/B reads, one pair per cycle unless hold
// S_DRAIN | 3 cycles letting the read/multiply/accumulate pipeline empty
// S_WRITE | one cycle presenting the result on C, accumulator cleared
// S_DONE  | one-cycle completion pulse
module macc_dot_engine #(
  parameter int DOT_LEN   = 64,
  parameter int NUM_OUT   = 64,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 64
) (
  input  logic             CLK,
  input  logic             RST_L,
  macc_dot_engine_if.slave bus
);

  localparam int PW = $clog2(DOT_LEN);
  localparam int OW = $clog2(NUM_OUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_nxt;
  logic [PW-1:0]           r_pair_cnt;
  logic [OW-1:0]           r_out_cnt;
  logic [1:0]              r_drain_cnt;
  logic                    w_accept;
  logic                    w_issue;
  logic                    w_last_pair;
  logic                    w_last_out;
  logic                    r_rd_vld;
  logic                    r_p0_vld;
  logic                    r_p1_vld;
  logic signed [31:0]      r_p0_a;
  logic signed [31:0]      r_p0_b;
  logic signed [63:0]      r_p1_prod;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             w_word;
  logic [31:0]             r_c_data;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_issue     = (r_state == S_RUN) && !bus.hold;
  assign w_last_pair = (r_pair_cnt == PW'(DOT_LEN - 1));
  assign w_last_out  = (r_out_cnt == OW'(NUM_OUT - 1));

  // State register
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state decode
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last_pair) w_nxt = S_DRAIN;
      S_DRAIN: if (r_drain_cnt == 2'd0) w_nxt = S_WRITE;
      S_WRITE: w_nxt = w_last_out ? S_DONE : S_RUN;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Pair, output and drain counters; drain timer counts down 2,1,0
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_pair_cnt  <= '0;
      r_out_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept || (r_state == S_WRITE)) r_pair_cnt <= '0;
      else if (w_issue)                     r_pair_cnt <= r_pair_cnt + PW'(1);

      if (w_accept)                 r_out_cnt <= '0;
      else if (r_state == S_WRITE)  r_out_cnt <= r_out_cnt + OW'(1);

      if (w_issue && w_last_pair)
        r_drain_cnt <= 2'd2;
      else if ((r_state == S_DRAIN) && (r_drain_cnt != 2'd0))
        r_drain_cnt <= r_drain_cnt - 2'd1;
    end
  end

  // Read-return capture and signed multiply stages
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      r_rd_vld  <= 1'b0;
      r_p0_vld  <= 1'b0;
      r_p1_vld  <= 1'b0;
      r_p0_a    <= '0;
      r_p0_b    <= '0;
      r_p1_prod <= '0;
    end else begin
      r_rd_vld <= w_issue;
      r_p0_vld <= r_rd_vld;
      r_p1_vld <= r_p0_vld;
      if (r_rd_vld) begin
        r_p0_a <= $signed(bus.a_data);
        r_p0_b <= $signed(bus.b_data);
      end
      if (r_p0_vld) r_p1_prod <= 64'(r_p0_a) * 64'(r_p0_b);
    end
  end

  assign w_prod_ext = ACC_W'(r_p1_prod);

  // Accumulator: cleared on start and after each write, wraps at ACC_W
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L)                               r_acc <= '0;
    else if (w_accept || (r_state == S_WRITE)) r_acc <= '0;
    else if (r_p1_vld)                         r_acc <= r_acc + w_prod_ext;
  end

`ifdef MACC_ENGINE_SAT_EN
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_clamp;
  logic                    r_ovf;

  assign w_shift = r_acc >>> FRAC_BITS;
  // In range only if every bit from 31 upward matches the sign
  assign w_clamp = !((&w_shift[ACC_W-1:31]) || !(|w_shift[ACC_W-1:31]));
  assign w_word  = w_clamp ? (w_shift[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                           : w_shift[31:0];

  // Sticky clamp flag, cleared by an accepted start
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L)                              r_ovf <= 1'b0;
    else if (w_accept)                       r_ovf <= 1'b0;
    else if ((r_state == S_WRITE) && w_clamp) r_ovf <= 1'b1;
  end

  assign bus.ovf = r_ovf;
`else
  assign w_word  = 32'(r_acc >>> FRAC_BITS);
  assign bus.ovf = 1'b0;
`endif

  // Holding register so c_data keeps the last written word between writes
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L)                  r_c_data <= '0;
    else if (r_state == S_WRITE) r_c_data <= w_word;
  end

  assign bus.a_re   = w_issue;
  assign bus.b_re   = w_issue;
  assign bus.c_we   = (r_state == S_WRITE);
  assign bus.c_data = (r_state == S_WRITE) ? w_word : r_c_data;
  assign bus.busy   = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_WRITE);
  assign bus.done   = (r_state == S_DONE);

endmodule
